// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the round-robin UART arbiter, its requesters and the shared
// 8N1 transmitter. Signal suffixes are from the arbiter's point of view.
interface uart_tx_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int WORD_BYTES = 4,
  parameter int DBIT       = 8,
  parameter int GID_W      = $clog2(N_REQ)
);

  logic [N_REQ-1:0]                  req_i;
  logic [N_REQ*WORD_BYTES*DBIT-1:0]  data_i;
  logic [N_REQ-1:0]                  ack_o;
  logic                              busy_o;
  logic [GID_W-1:0]                  grant_id_o;
  logic                              tx_start_o;
  logic [DBIT-1:0]                   tx_din_o;
  logic                              tx_done_i;

  // Arbiter side
  modport master (
    input  req_i,
    input  data_i,
    input  tx_done_i,
    output ack_o,
    output busy_o,
    output grant_id_o,
    output tx_start_o,
    output tx_din_o
  );

  // Requesters plus transmitter side
  modport slave (
    output req_i,
    output data_i,
    output tx_done_i,
    input  ack_o,
    input  busy_o,
    input  grant_id_o,
    input  tx_start_o,
    input  tx_din_o
  );

endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ requesters.
// Each grant latches one WORD_BYTES-byte word and sends it LSB first, one
// tx_start/tx_done handshake per byte, then pulses the requester's ack.
module uart_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int WORD_BYTES = 4,
  parameter int DBIT       = 8,
  parameter int GID_W      = $clog2(N_REQ)
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_arbiter_if.master bus
);

  localparam int SHIFT_W = WORD_BYTES * DBIT;
  localparam int BCNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);
  localparam logic [GID_W-1:0]  LAST_REQ  = GID_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [GID_W-1:0]    rrPtr_q, rrPtr_d;
  logic [GID_W-1:0]    grantId_q, grantId_d;
  logic [BCNT_W-1:0]   byteCnt_q, byteCnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;

  logic [GID_W-1:0]    winner;
  logic                anyReq;
  logic [N_REQ-1:0]    ackVec;
  logic                txStart;
  logic [DBIT-1:0]     txDin;

  // Pick the first active requester at or after rrPtr, wrapping around
  always_comb begin
    int idx;
    logic [GID_W-1:0] idxSel;
    winner = rrPtr_q;
    anyReq = |bus.req_i;
    idx    = 0;
    idxSel = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      idxSel = GID_W'(idx);
      if (bus.req_i[idxSel]) begin
        winner = idxSel;
      end
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      grantId_q <= '0;
      byteCnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      grantId_q <= grantId_d;
      byteCnt_q <= byteCnt_d;
      shift_q   <= shift_d;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d   = state_q;
    rrPtr_d   = rrPtr_q;
    grantId_d = grantId_q;
    byteCnt_d = byteCnt_q;
    shift_d   = shift_q;
    ackVec    = '0;
    txStart   = 1'b0;
    txDin     = '0;
    case (state_q)
      IDLE: begin
        if (anyReq) begin
          grantId_d = winner;
          shift_d   = bus.data_i[winner * SHIFT_W +: SHIFT_W];
          byteCnt_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        txStart = 1'b1;
        txDin   = shift_q[DBIT-1:0];
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.tx_done_i) begin
          if (byteCnt_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            shift_d   = shift_q >> DBIT;
            byteCnt_d = byteCnt_q + BCNT_W'(1);
            state_d   = SEND;
          end
        end
      end
      DONE: begin
        ackVec[grantId_q] = 1'b1;
        rrPtr_d = (grantId_q == LAST_REQ) ? '0 : grantId_q + GID_W'(1);
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ack_o      = ackVec;
  assign bus.busy_o     = (state_q != IDLE);
  assign bus.grant_id_o = grantId_q;
  assign bus.tx_start_o = txStart;
  assign bus.tx_din_o   = txDin;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected words are queued when
// requests are driven and compared byte by byte as the arbiter feeds a
// modelled transmitter that answers each tx_start with tx_done 20 cycles later.
module tb_uart_tx_arbiter;

  localparam int N_REQ      = 4;
  localparam int WORD_BYTES = 4;
  localparam int DBIT       = 8;
  localparam int DATA_W     = N_REQ * WORD_BYTES * DBIT;

  typedef struct {
    int          gid;
    logic [31:0] word;
  } expWord_t;

  logic clk;
  logic reset;
  logic modelDone;
  logic spurDone;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .WORD_BYTES(WORD_BYTES), .DBIT(DBIT)) bus ();

  uart_tx_arbiter #(.N_REQ(N_REQ), .WORD_BYTES(WORD_BYTES), .DBIT(DBIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.tx_done_i = modelDone | spurDone;

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;
  int lastDoneCycle = 0;
  int countdown = 0;
  int ackTotal = 0;
  int ackCount [N_REQ];
  int base [N_REQ];

  expWord_t expQ [$];
  expWord_t cur;
  logic     active = 1'b0;
  int       byteIdx = 0;
  logic     prevStart = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] reqVal,
                               input logic [DATA_W-1:0] dataVal);
    @(negedge clk);
    bus.req_i  = reqVal;
    bus.data_i = dataVal;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_ack"},      bus.ack_o, 0);
    checkOutput({tag, "_busy"},     bus.busy_o, 0);
    checkOutput({tag, "_grant_id"}, bus.grant_id_o, 0);
    checkOutput({tag, "_tx_start"}, bus.tx_start_o, 0);
    checkOutput({tag, "_tx_din"},   bus.tx_din_o, 0);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((bus.busy_o || active) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy_o || active) checkOutput("idle_timeout", bus.busy_o, 0);
  endtask

  task automatic waitAcks(input int target, input int budget);
    int n = 0;
    while (ackTotal < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ackTotal < target) checkOutput("ack_timeout", ackTotal, target);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] sliceOf(input logic [DATA_W-1:0] d, input int i);
    return d[i*32 +: 32];
  endfunction

  // Transmitter model: tx_done one cycle wide, 20 cycles after each tx_start
  initial begin : txModel
    modelDone = 1'b0;
    forever begin
      @(negedge clk);
      modelDone = 1'b0;
      if (reset) begin
        countdown = 0;
      end else begin
        if (countdown > 0) begin
          countdown--;
          if (countdown == 0) begin
            modelDone = 1'b1;
            lastDoneCycle = cycleCnt;
          end
        end
        if (bus.tx_start_o) countdown = 20;
      end
    end
  end

  // Output monitor: pops the scoreboard on each grant and checks every byte and ack
  initial begin : monitor
    for (int i = 0; i < N_REQ; i++) ackCount[i] = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active    = 1'b0;
        prevStart = 1'b0;
      end else begin
        if (bus.tx_start_o) begin
          checkOutput("start_width", prevStart, 1'b0);
          if (!active) begin
            checkOutput("grant_expected", expQ.size() != 0, 1'b1);
            if (expQ.size() != 0) begin
              cur     = expQ.pop_front();
              active  = 1'b1;
              byteIdx = 0;
              checkOutput("grant_id", bus.grant_id_o, cur.gid);
            end
          end else begin
            checkOutput("start_gap", cycleCnt - lastDoneCycle, 1);
          end
          if (active) begin
            checkOutput("byte_in_word", byteIdx < WORD_BYTES, 1'b1);
            if (byteIdx < WORD_BYTES) begin
              checkOutput("tx_din", bus.tx_din_o, cur.word[byteIdx*8 +: 8]);
              byteIdx++;
            end
          end
        end
        if (bus.ack_o != '0) begin
          checkOutput("ack_value", bus.ack_o,
                      (active && byteIdx == WORD_BYTES) ? (4'b0001 << cur.gid) : 4'b0000);
          checkOutput("ack_latency", cycleCnt - lastDoneCycle, 1);
          for (int i = 0; i < N_REQ; i++) begin
            if (bus.ack_o[i]) ackCount[i]++;
          end
          ackTotal++;
          active = 1'b0;
        end
        prevStart = bus.tx_start_o;
      end
    end
  end

  // Main stimulus sequence
  initial begin : stimulus
    logic [DATA_W-1:0] dataVal;
    int waitN;
    reset      = 1'b1;
    spurDone   = 1'b0;
    bus.req_i  = '0;
    bus.data_i = '0;
    repeat (3) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;

    // tx_done while idle must not wake the arbiter
    @(negedge clk);
    spurDone = 1'b1;
    @(negedge clk);
    spurDone = 1'b0;
    checkOutput("idle_spur_busy", bus.busy_o, 0);
    checkOutput("idle_spur_start", bus.tx_start_o, 0);

    // Single request, first-byte latency, tx_done during SEND, req dropped after grant
    dataVal = {32'h0BAD0003, 32'h0BAD0002, 32'hA1B2C3D4, 32'h0BAD0000};
    expQ.push_back('{1, 32'hA1B2C3D4});
    applyStimulus(4'b0010, dataVal);
    @(negedge clk);
    checkOutput("lat_start", bus.tx_start_o, 1);
    checkOutput("lat_din", bus.tx_din_o, 8'hD4);
    checkOutput("lat_gid", bus.grant_id_o, 1);
    spurDone   = 1'b1;
    bus.req_i  = '0;
    bus.data_i = '1;
    @(negedge clk);
    spurDone = 1'b0;
    checkOutput("send_spur_start", bus.tx_start_o, 0);
    checkOutput("send_spur_busy", bus.busy_o, 1);
    waitIdle(300);
    checkOutput("single_ack_count", ackCount[1], 1);
    checkOutput("single_busy_after", bus.busy_o, 0);

    // All four requesting from a fresh pointer: order 0,1,2,3,0,1,2,3
    pulseReset();
    dataVal = {32'h44434241, 32'h34333231, 32'h24232221, 32'h14131211};
    for (int k = 0; k < 8; k++) expQ.push_back('{k % 4, sliceOf(dataVal, k % 4)});
    for (int i = 0; i < N_REQ; i++) base[i] = ackCount[i];
    waitN = ackTotal + 8;
    applyStimulus(4'b1111, dataVal);
    waitAcks(waitN, 2500);
    bus.req_i = '0;
    waitIdle(200);
    for (int i = 0; i < N_REQ; i++) checkOutput("all_acks", ackCount[i] - base[i], 2);

    // Fairness between requesters 0 and 2 held continuously
    dataVal = {32'hDEAD0003, 32'h5A5A0F0F, 32'hDEAD0001, 32'hC0FFEE11};
    for (int k = 0; k < 4; k++) expQ.push_back('{(k % 2) * 2, sliceOf(dataVal, (k % 2) * 2)});
    for (int i = 0; i < N_REQ; i++) base[i] = ackCount[i];
    waitN = ackTotal + 4;
    applyStimulus(4'b0101, dataVal);
    waitAcks(waitN, 1500);
    bus.req_i = '0;
    waitIdle(200);
    checkOutput("fair_req0", ackCount[0] - base[0], 2);
    checkOutput("fair_req1", ackCount[1] - base[1], 0);
    checkOutput("fair_req2", ackCount[2] - base[2], 2);
    checkOutput("fair_req3", ackCount[3] - base[3], 0);

    // Reset after the second byte abandons the word; pointer returns to 0
    dataVal = {32'h00000000, 32'h87654321, 32'h00000000, 32'h00000000};
    expQ.push_back('{2, 32'h87654321});
    for (int i = 0; i < N_REQ; i++) base[i] = ackCount[i];
    applyStimulus(4'b0100, dataVal);
    @(negedge clk);
    bus.req_i = '0;
    waitN = 0;
    while (byteIdx < 3 && waitN < 200) begin
      @(negedge clk);
      waitN++;
    end
    checkOutput("third_byte_seen", byteIdx, 3);
    reset = 1'b1;
    @(negedge clk);
    checkReset("mid_reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("mid_reset_no_ack", ackCount[2] - base[2], 0);

    dataVal = {32'h13579BDF, 32'h0, 32'h0, 32'h0};
    expQ.push_back('{3, 32'h13579BDF});
    applyStimulus(4'b1000, dataVal);
    @(negedge clk);
    checkOutput("post_reset_start", bus.tx_start_o, 1);
    checkOutput("post_reset_gid", bus.grant_id_o, 3);
    checkOutput("post_reset_din", bus.tx_din_o, 8'hDF);
    bus.req_i = '0;
    waitIdle(300);
    checkOutput("post_reset_ack", ackCount[3] - base[3], 1);
    checkOutput("scoreboard_empty", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter (8N1 serializer with tx_start/din/tx_done handshake) among N_REQ requesters.
- Each grant sends one WORD_BYTES-byte word, least-significant byte first, then acks the requester.
- Sits between debug/report sources (register dump, PC, memory readback) and the single UART TX line.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WORD_BYTES, 4, bytes sent per grant (1..8).
- DBIT, 8, data bits per UART byte; must match the transmitter's DBIT.
- GID_W, $clog2(N_REQ), width of grant_id (derived; do not override).

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  level request; bit i high = requester i has a word pending.
- data  in  N_REQ*WORD_BYTES*DBIT  flattened words; requester i occupies slice [i*WORD_BYTES*DBIT +: WORD_BYTES*DBIT].
- ack  out  N_REQ  one-cycle pulse on bit i when requester i's word is fully sent.
- busy  out  1  high whenever state != IDLE.
- grant_id  out  GID_W  index of the current or last granted requester.
- tx_start  out  1  to transmitter; one-cycle start pulse.
- tx_din  out  DBIT  to transmitter; byte to send, valid while tx_start=1.
- tx_done  in  1  from transmitter; one-cycle end-of-stop-bit pulse.

Behaviour:
- Reset (synchronous): state=IDLE, rr_ptr=0, grant_id=0, byte_cnt=0, shift register=0. ack=0, busy=0, tx_start=0, tx_din=0.
- FSM states: IDLE, SEND, WAIT, DONE. tx_start = (state==SEND). tx_din = shift[DBIT-1:0] in SEND, 0 otherwise.
- IDLE, req==0: stay in IDLE.
- IDLE, req!=0: select the first set bit searching rr_ptr, rr_ptr+1, ... with wrap mod N_REQ. On the same edge:
  - grant_id <= winner.
  - shift <= winner's data slice.
  - byte_cnt <= 0.
  - state <= SEND.
- SEND: lasts exactly 1 cycle; tx_start=1; then state <= WAIT.
- WAIT: hold until tx_done=1.
  - If byte_cnt==WORD_BYTES-1: state <= DONE.
  - Otherwise: shift <= shift >> DBIT, byte_cnt++, state <= SEND.
- DONE: lasts exactly 1 cycle.
  - ack[grant_id]=1.
  - rr_ptr <= (grant_id==N_REQ-1) ? 0 : grant_id+1.
  - state <= IDLE.
- Latency:
  - req sampled high in IDLE at edge k -> tx_start high in cycle k+1.
  - Last tx_done at edge m -> ack pulse in cycle m+1.
  - Next grant is decided in IDLE at cycle m+2.
- Between bytes: tx_start rises the cycle after tx_done. The transmitter is already back in its IDLE state then, so no byte is dropped.
- data is captured only at grant and may change afterwards. req is only examined in IDLE.
- Deasserting req mid-word does not abort the word; ack is still pulsed.
- A requester holding req high after ack is re-granted only after every other active requester has been served once (fairness).
- tx_done in IDLE, SEND or DONE is ignored; no state change.
- Only one ack bit is ever high at a time. ack is never asserted without a preceding grant.
- Reset mid-word: the word is abandoned, no ack, rr_ptr=0. The transmitter shares the reset.
- byte_cnt is wide enough for WORD_BYTES-1. shift width = WORD_BYTES*DBIT. Zero-fill on right shift.

Test Plan:
- Single request: req=4'b0010, data slice1=32'hA1B2C3D4, model transmitter with tx_done 20 cycles after each tx_start -> tx_din sequence D4, C3, B2, A1; tx_start one cycle each; ack=4'b0010 exactly once, 1 cycle after 4th tx_done; busy low after that.
- All requesting: req=4'b1111 held, distinct words -> grant_id order 0,1,2,3,0...; each word byte-correct; one ack per word.
- Fairness: req0 and req2 held continuously -> grants alternate 0,2,0,2; requesters 1 and 3 never acked.
- Latency: req goes high while IDLE at edge k -> tx_start=1 in cycle k+1 with tx_din equal to the low byte.
- Spurious/early signals:
  - tx_done pulsed in IDLE and during SEND -> no state change and no extra tx_start.
  - req dropped after grant -> word still completes and ack issued.
- Reset mid-word: assert reset after 2nd byte -> next cycle all outputs 0, busy=0, no ack. A subsequent req=4'b1000 is granted with grant_id=3, searched from rr_ptr=0.
